// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the MAC operand-feed sequencer.
package mac_seq_pkg;

  localparam int ACC_W  = 32;
  localparam int OPND_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/mac_feed_sequencer.sv
// Streams num_macs operand pairs from a 1-cycle-latency memory into an external
// uint8 MAC, then captures the accumulated dot product.
module mac_feed_sequencer
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_macs,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [OPND_W-1:0] mac_data_in,
  output logic [OPND_W-1:0] mac_weight_in,
  output logic              mac_enable,
  output logic              mac_clear_acc,
  input  logic [ACC_W-1:0]  mac_acc_in
);

  seq_state_t        state, state_nx;
  logic [LEN_W-1:0]  len, cnt;
  logic [ADDR_W-1:0] addr;

  assign mem_addr = addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    busy          = 1'b1;
    done          = 1'b0;
    mem_en        = 1'b0;
    mac_enable    = 1'b0;
    mac_clear_acc = 1'b0;
    mac_data_in   = '0;
    mac_weight_in = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (num_macs == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        mac_clear_acc = 1'b1;
        mem_en        = 1'b1;
        state_nx      = S_STREAM;
      end
      S_STREAM: begin
        mac_enable    = 1'b1;
        mac_data_in   = mem_rdata[15:8];
        mac_weight_in = mem_rdata[7:0];
        // prefetch the next pair only while one remains; len >= 1 here
        mem_en        = (cnt < len - LEN_W'(1));
        if (cnt == len - LEN_W'(1)) state_nx = S_DRAIN;
      end
      S_DRAIN: state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // addr holds the latched base, then walks one ahead of the pair being consumed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len    <= '0;
      cnt    <= '0;
      addr   <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          len  <= num_macs;
          addr <= base_addr;
          cnt  <= '0;
          if (num_macs == '0) result <= '0;
        end
        S_CLEAR: begin
          addr <= addr + ADDR_W'(1);
          cnt  <= '0;
        end
        S_STREAM: begin
          addr <= addr + ADDR_W'(1);
          cnt  <= cnt + LEN_W'(1);
        end
        S_DRAIN: result <= mac_acc_in;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_feed_sequencer.sv
// Scoreboard bench: sequencer paired with a behavioural uint8 MAC and operand memory.
module tb_mac_feed_sequencer;

  localparam int ADDR_W = 9;
  localparam int LEN_W  = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock, reset, start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_macs;
  logic              busy, done, mem_en, mac_enable, mac_clear_acc;
  logic [31:0]       result, mac_acc;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic [7:0]        mac_data_in, mac_weight_in;

  mac_feed_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .base_addr(base_addr), .num_macs(num_macs),
    .busy(busy), .done(done), .result(result),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mac_data_in(mac_data_in), .mac_weight_in(mac_weight_in),
    .mac_enable(mac_enable), .mac_clear_acc(mac_clear_acc),
    .mac_acc_in(mac_acc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] mem [DEPTH];
  int cyc = 0;
  int checks = 0;
  int passes = 0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (mem_en) mem_rdata <= mem[mem_addr];

  always @(posedge clock or negedge reset) begin
    if (!reset)             mac_acc <= '0;
    else if (mac_clear_acc) mac_acc <= '0;
    else if (mac_enable)    mac_acc <= mac_acc + 32'(mac_data_in) * 32'(mac_weight_in);
  end

  typedef struct {
    int unsigned res;
    int          t_done;
    int          n;
    int          base;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  function automatic int unsigned ref_dot(input int b, input int n);
    int unsigned s = 0;
    for (int i = 0; i < n; i++) begin
      logic [15:0] w;
      w = mem[(b + i) % DEPTH];
      s += int'(w[15:8]) * int'(w[7:0]);
    end
    return s;
  endfunction

  // monitor: tallies per-run activity and scores it when done appears
  int n_en, n_clr, n_me, bad_op;
  int addr_obs[$];

  always @(negedge clock) begin
    if (!reset) begin
      n_en = 0; n_clr = 0; n_me = 0; bad_op = 0;
      addr_obs.delete();
    end else begin
      if (mac_enable) n_en++;
      if (mac_clear_acc) n_clr++;
      if (mem_en) begin n_me++; addr_obs.push_back(int'(mem_addr)); end
      if (!mac_enable && (mac_data_in != 0 || mac_weight_in != 0)) bad_op++;
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          int bad_addr;
          e = exp_q.pop_front();
          bad_addr = 0;
          for (int i = 0; i < addr_obs.size(); i++)
            if (addr_obs[i] != (e.base + i) % DEPTH) bad_addr++;
          chk("result", result, e.res);
          chk("done_cycle", cyc, e.t_done);
          chk("mac_enable_cycles", n_en, e.n);
          chk("clear_pulses", n_clr, (e.n != 0) ? 1 : 0);
          chk("mem_en_cycles", n_me, e.n);
          chk("addr_seq_errors", bad_addr, 0);
          chk("idle_operand_errors", bad_op, 0);
        end
        n_en = 0; n_clr = 0; n_me = 0; bad_op = 0;
        addr_obs.delete();
      end
    end
  end

  function automatic longint out_vec();
    return longint'({busy, done, result, mem_en, mem_addr, mac_enable,
                     mac_clear_acc, mac_data_in, mac_weight_in});
  endfunction

  // cyc after the sampling edge is t0; done is seen N+2 edges later (N>0) or on t0 itself
  task automatic issue(input int b, input int n);
    @(negedge clock);
    start = 1'b1;
    base_addr = ADDR_W'(b);
    num_macs  = LEN_W'(n);
    exp_q.push_back('{ref_dot(b, n), cyc + 1 + ((n != 0) ? n + 2 : 0), n, b});
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic run(input int b, input int n);
    issue(b, n);
    wait_idle(n + 20);
  endtask

  task automatic load_68();
    mem[0] = 16'h0203; mem[1] = 16'h0405; mem[2] = 16'h0607;
  endtask

  initial begin
    start = 1'b0; base_addr = '0; num_macs = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i * 7 + 3);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 chk("reset_outputs", out_vec(), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    load_68();
    run(0, 3);
    run(0, 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hFFFF;
    run(17, 511);

    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    run(510, 4);

    // start re-pulsed mid-stream must not queue a second run
    issue(40, 20);
    repeat (5) @(negedge clock);
    start = 1'b1; base_addr = 9'd100; num_macs = 9'd7;
    @(negedge clock);
    start = 1'b0;
    wait_idle(60);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
      run($urandom_range(0, DEPTH - 1), $urandom_range(0, 40));
    end

    // reset mid-stream: outputs drop without an edge, run is abandoned
    issue(50, 30);
    repeat (6) @(negedge clock);
    #2 reset = 1'b0;
    #1 chk("midrun_reset_outputs", out_vec(), 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    load_68();
    run(0, 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
